// File: rtl/lcd_sequencer.sv
// lcd_sequencer
// Drives a single-byte HD44780-style LCD writer. After reset it waits out the
// LCD power-up time, plays the fixed init command list, and from then on drains
// a small character FIFO into display RAM while tracking the cursor position.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   char_valid/char_data  host byte stream (0x0A is a newline request)
//   char_ready            FIFO can take a byte this cycle
//   clear_req             one-cycle request to clear the display and home the cursor
//   wr_start/wr_rs/wr_data/wr_done   handshake with the byte writer
//   init_done             init command list finished (sticky until reset)
//   busy                  sequencer active or characters still queued
//   cur_col/cur_line      cursor position the next character will land on
module lcd_sequencer #(
    parameter int FIFO_DEPTH        = 16,
    parameter int POWERUP_CYCLES    = 750000,
    parameter int CLEAR_WAIT_CYCLES = 80000,
    parameter int LINE_LEN          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       wr_start,
    output logic       wr_rs,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       init_done,
    output logic       busy,
    output logic [3:0] cur_col,
    output logic       cur_line
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int FCW     = AW + 1;
    localparam int CNT_MAX = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [2:0] INIT_LAST = 3'd5;

    typedef enum logic [3:0] {
        POWERUP,
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        CHAR_ISSUE,
        CHAR_WAIT,
        NL_ISSUE,
        NL_WAIT,
        CLR_ISSUE,
        CLR_WAIT,
        DELAY
    } state_t;

    typedef enum logic {
        RET_INIT,
        RET_IDLE
    } delay_ret_t;

    state_t        state;
    delay_ret_t    delay_ret;
    logic [CW-1:0] counter;
    logic [2:0]    init_idx;
    logic [7:0]    init_byte;
    logic [7:0]    char_byte;
    logic          clear_pend;

    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [FCW-1:0] fifo_count;
    logic [7:0]     head_byte;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;

    // The FSM only pops from IDLE when no clear is waiting, so the pop decision
    // depends on registers alone. That lets char_ready admit a byte into a full
    // FIFO in the same cycle the head is being taken out.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FCW'(FIFO_DEPTH));
    assign pop        = (state == IDLE) && !clear_pend && !fifo_empty;
    assign char_ready = !fifo_full || pop;
    assign push       = char_valid && char_ready;
    assign head_byte  = fifo_mem[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;

    // Fixed init command list: 8-bit/2-line mode twice, display on, clear,
    // entry mode increment, cursor home to line 0.
    always_comb begin
        init_byte = 8'h80;
        case (init_idx)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h38;
            3'd2:    init_byte = 8'h0C;
            3'd3:    init_byte = 8'h01;
            3'd4:    init_byte = 8'h06;
            default: init_byte = 8'h80;
        endcase
    end

    // FIFO storage has no reset; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= char_data;
        end
    end

    // FIFO pointers and occupancy. Depth is a power of two, so the pointers
    // wrap naturally; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Main sequencer. wr_start defaults low every cycle so an ISSUE state
    // produces exactly one pulse. In the WAIT states a wr_done that coincides
    // with our own start pulse is ignored, since it cannot belong to this
    // transfer. A clear request arriving in the same cycle the pending clear is
    // being issued is kept, so it is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= POWERUP;
            delay_ret  <= RET_INIT;
            counter    <= '0;
            init_idx   <= '0;
            char_byte  <= 8'h00;
            clear_pend <= 1'b0;
            wr_start   <= 1'b0;
            wr_rs      <= 1'b0;
            wr_data    <= 8'h00;
            init_done  <= 1'b0;
            cur_col    <= 4'd0;
            cur_line   <= 1'b0;
        end else begin
            wr_start <= 1'b0;
            if (clear_req) begin
                clear_pend <= 1'b1;
            end

            case (state)
                POWERUP: begin
                    if (counter == CW'(POWERUP_CYCLES - 1)) begin
                        counter <= '0;
                        state   <= INIT_ISSUE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                INIT_ISSUE: begin
                    wr_start <= 1'b1;
                    wr_rs    <= 1'b0;
                    wr_data  <= init_byte;
                    state    <= INIT_WAIT;
                end

                INIT_WAIT: begin
                    if (wr_done && !wr_start) begin
                        if (init_idx == INIT_LAST) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            if (init_byte == 8'h01) begin
                                counter   <= '0;
                                delay_ret <= RET_INIT;
                                state     <= DELAY;
                            end else begin
                                state <= INIT_ISSUE;
                            end
                        end
                    end
                end

                IDLE: begin
                    if (clear_pend) begin
                        state <= CLR_ISSUE;
                    end else if (!fifo_empty) begin
                        if (head_byte == 8'h0A) begin
                            cur_line <= ~cur_line;
                            cur_col  <= 4'd0;
                            state    <= NL_ISSUE;
                        end else begin
                            char_byte <= head_byte;
                            state     <= CHAR_ISSUE;
                        end
                    end
                end

                CHAR_ISSUE: begin
                    wr_start <= 1'b1;
                    wr_rs    <= 1'b1;
                    wr_data  <= char_byte;
                    state    <= CHAR_WAIT;
                end

                CHAR_WAIT: begin
                    if (wr_done && !wr_start) begin
                        if (cur_col == 4'(LINE_LEN - 1)) begin
                            cur_col  <= 4'd0;
                            cur_line <= ~cur_line;
                            state    <= NL_ISSUE;
                        end else begin
                            cur_col <= cur_col + 4'd1;
                            state   <= IDLE;
                        end
                    end
                end

                NL_ISSUE: begin
                    wr_start <= 1'b1;
                    wr_rs    <= 1'b0;
                    wr_data  <= cur_line ? 8'hC0 : 8'h80;
                    state    <= NL_WAIT;
                end

                NL_WAIT: begin
                    if (wr_done && !wr_start) begin
                        state <= IDLE;
                    end
                end

                CLR_ISSUE: begin
                    wr_start   <= 1'b1;
                    wr_rs      <= 1'b0;
                    wr_data    <= 8'h01;
                    clear_pend <= clear_req;
                    cur_col    <= 4'd0;
                    cur_line   <= 1'b0;
                    state      <= CLR_WAIT;
                end

                CLR_WAIT: begin
                    if (wr_done && !wr_start) begin
                        counter   <= '0;
                        delay_ret <= RET_IDLE;
                        state     <= DELAY;
                    end
                end

                DELAY: begin
                    if (counter == CW'(CLEAR_WAIT_CYCLES - 1)) begin
                        counter <= '0;
                        state   <= (delay_ret == RET_INIT) ? INIT_ISSUE : IDLE;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                default: state <= POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer
// Directed plus randomized bench for lcd_sequencer. A writer model answers each
// start pulse with a one-cycle done a fixed latency later (optionally stalled),
// and records every transfer. Expected transfers come from a cursor model that
// works purely from the character stream: printable bytes advance the column,
// a full line or a newline emits a line address, a clear emits 0x01.
module tb_lcd_sequencer;

    localparam int FIFO_DEPTH        = 16;
    localparam int POWERUP_CYCLES    = 20;
    localparam int CLEAR_WAIT_CYCLES = 10;
    localparam int LINE_LEN          = 16;
    localparam int WR_LATENCY        = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       clear_req;
    logic       wr_start;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       init_done;
    logic       busy;
    logic [3:0] cur_col;
    logic       cur_line;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic stall    = 1'b0;
    logic writer_active;

    logic       got_rs[$];
    logic [7:0] got_data[$];
    int         got_cyc[$];
    logic [3:0] got_col[$];
    logic       got_line[$];
    logic       exp_rs[$];
    logic [7:0] exp_data[$];
    int         m_col  = 0;
    int         m_line = 0;

    lcd_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .POWERUP_CYCLES(POWERUP_CYCLES),
        .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES),
        .LINE_LEN(LINE_LEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .char_valid(char_valid),
        .char_data(char_data),
        .char_ready(char_ready),
        .clear_req(clear_req),
        .wr_start(wr_start),
        .wr_rs(wr_rs),
        .wr_data(wr_data),
        .wr_done(wr_done),
        .init_done(init_done),
        .busy(busy),
        .cur_col(cur_col),
        .cur_line(cur_line)
    );

    // 10-time-unit clock and a free-running cycle count for timing checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Writer model: logs each start pulse, then answers with a one-cycle done
    // WR_LATENCY cycles later, or later still while stall is held.
    initial begin
        wr_done       = 1'b0;
        writer_active = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && wr_start === 1'b1) begin
                writer_active = 1'b1;
                got_rs.push_back(wr_rs);
                got_data.push_back(wr_data);
                got_cyc.push_back(cyc);
                got_col.push_back(cur_col);
                got_line.push_back(cur_line);
                repeat (WR_LATENCY - 1) @(negedge clk);
                while (stall) @(negedge clk);
                wr_done = 1'b1;
                @(negedge clk);
                wr_done       = 1'b0;
                writer_active = 1'b0;
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic addExpected(input logic rs, input logic [7:0] data);
        exp_rs.push_back(rs);
        exp_data.push_back(data);
    endtask

    task automatic modelChar(input logic [7:0] c);
        if (c == 8'h0A) begin
            m_line = 1 - m_line;
            m_col  = 0;
            addExpected(1'b0, (m_line == 1) ? 8'hC0 : 8'h80);
        end else begin
            addExpected(1'b1, c);
            m_col++;
            if (m_col == LINE_LEN) begin
                m_col  = 0;
                m_line = 1 - m_line;
                addExpected(1'b0, (m_line == 1) ? 8'hC0 : 8'h80);
            end
        end
    endtask

    task automatic modelClear();
        addExpected(1'b0, 8'h01);
        m_col  = 0;
        m_line = 0;
    endtask

    task automatic clearLogs();
        got_rs.delete();
        got_data.delete();
        got_cyc.delete();
        got_col.delete();
        got_line.delete();
        exp_rs.delete();
        exp_data.delete();
    endtask

    // Push one byte through the valid/ready handshake and feed it to the model.
    task automatic applyStimulus(input logic [7:0] c);
        int n = 0;
        char_valid = 1'b1;
        char_data  = c;
        while (char_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("push_accept", char_ready, 1'b1);
        @(negedge clk);
        char_valid = 1'b0;
        modelChar(c);
    endtask

    task automatic pulseClear();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < 5000) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0 && writer_active == 1'b0) quiet++;
            else quiet = 0;
        end
        checkOutput({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic waitStarts(input string tag, input int target);
        int n = 0;
        while (got_rs.size() < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_started"}, got_rs.size(), target);
    endtask

    task automatic waitInit();
        int n = 0;
        while (init_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("init_done", init_done, 1'b1);
    endtask

    // Compares the logged transfers with the model in order, then clears both.
    task automatic compareTransfers(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_rs.size(), exp_rs.size());
        n = (got_rs.size() < exp_rs.size()) ? got_rs.size() : exp_rs.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_rs%0d", tag, i), got_rs[i], exp_rs[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
        clearLogs();
    endtask

    task automatic checkCursor(input string tag);
        checkOutput({tag, "_col"}, cur_col, m_col);
        checkOutput({tag, "_line"}, cur_line, m_line);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr_start"}, wr_start, 1'b0);
        checkOutput({tag, "_wr_rs"}, wr_rs, 1'b0);
        checkOutput({tag, "_wr_data"}, wr_data, 8'h00);
        checkOutput({tag, "_init_done"}, init_done, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b1);
        checkOutput({tag, "_cur_col"}, cur_col, 4'd0);
        checkOutput({tag, "_cur_line"}, cur_line, 1'b0);
        checkOutput({tag, "_char_ready"}, char_ready, 1'b1);
    endtask

    // Init list content, first-command timing and the post-clear delay.
    task automatic checkInitSequence(input string tag, input int rel);
        logic [7:0] init_tbl [6];
        init_tbl = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        checkOutput({tag, "_xfers"}, got_rs.size(), 6);
        if (got_rs.size() >= 5) begin
            checkOutput({tag, "_first_start_window"},
                        ((got_cyc[0] - rel) >= POWERUP_CYCLES) && ((got_cyc[0] - rel) <= POWERUP_CYCLES + 1), 1'b1);
            checkOutput({tag, "_clear_gap_ok"},
                        (got_cyc[4] - got_cyc[3]) >= CLEAR_WAIT_CYCLES + WR_LATENCY, 1'b1);
        end
        for (int i = 0; i < 6; i++) addExpected(1'b0, init_tbl[i]);
        compareTransfers(tag);
        m_col  = 0;
        m_line = 0;
        checkCursor(tag);
    endtask

    initial begin
        int rel;
        int clr_idx;
        int clr_cnt;
        int burst_len;
        logic [7:0] c;

        reset      = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        clear_req  = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rst");

        // Power-up delay and init list.
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc;
        waitInit();
        checkInitSequence("init", rel);

        // Two characters.
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        waitIdle("ab");
        compareTransfers("ab");
        checkCursor("ab");

        // Two newlines bring the cursor back to line 0, column 0.
        applyStimulus(8'h0A);
        applyStimulus(8'h0A);
        waitIdle("nl2");
        compareTransfers("nl2");
        checkCursor("nl2");

        // A full line wraps to line 1, then a newline wraps back to line 0.
        for (int i = 0; i < 16; i++) begin
            c = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
            applyStimulus(c);
        end
        waitIdle("line");
        compareTransfers("line");
        checkCursor("line");
        checkOutput("line_wrap_line", cur_line, 1'b1);
        applyStimulus(8'h0A);
        waitIdle("nl");
        compareTransfers("nl");
        checkCursor("nl");

        // Stalled writer: the FIFO fills and refuses further bytes.
        stall = 1'b1;
        applyStimulus(8'h61);
        waitStarts("full_head", 1);
        for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(8'(8'h62 + i));
        checkOutput("full_char_ready", char_ready, 1'b0);
        checkOutput("full_busy", busy, 1'b1);
        char_valid = 1'b1;
        char_data  = 8'hEE;
        repeat (3) @(negedge clk);
        char_valid = 1'b0;
        stall = 1'b0;
        waitIdle("full");
        compareTransfers("full");
        checkCursor("full");

        // Two clear pulses during one character write collapse to one clear.
        stall = 1'b1;
        applyStimulus(8'h58);
        waitStarts("clr_head", 1);
        applyStimulus(8'h59);
        applyStimulus(8'h5A);
        // The clear lands after the in-flight character, ahead of the queued ones.
        exp_rs.delete();
        exp_data.delete();
        m_col  = (m_col + LINE_LEN - 3) % LINE_LEN;
        m_line = 0;
        modelChar(8'h58);
        pulseClear();
        repeat (2) @(negedge clk);
        pulseClear();
        modelClear();
        modelChar(8'h59);
        modelChar(8'h5A);
        stall = 1'b0;
        waitIdle("clr");
        clr_cnt = 0;
        clr_idx = -1;
        for (int i = 0; i < got_rs.size(); i++) begin
            if (got_rs[i] == 1'b0 && got_data[i] == 8'h01) begin
                clr_cnt++;
                if (clr_idx < 0) clr_idx = i;
            end
        end
        checkOutput("clr_once", clr_cnt, 1);
        if (clr_idx >= 0 && clr_idx + 1 < got_rs.size()) begin
            checkOutput("clr_gap_ok", (got_cyc[clr_idx + 1] - got_cyc[clr_idx]) >= CLEAR_WAIT_CYCLES + WR_LATENCY, 1'b1);
            checkOutput("clr_col", got_col[clr_idx], 4'd0);
            checkOutput("clr_line", got_line[clr_idx], 1'b0);
        end
        compareTransfers("clr");
        checkCursor("clr");

        // Random character bursts against the cursor model.
        for (int b = 0; b < 4; b++) begin
            burst_len = $urandom_range(4, 24);
            for (int i = 0; i < burst_len; i++) begin
                if ($urandom_range(0, 7) == 0) c = 8'h0A;
                else c = 8'($urandom_range(32, 126));
                applyStimulus(c);
            end
            waitIdle($sformatf("rnd%0d", b));
            compareTransfers($sformatf("rnd%0d", b));
            checkCursor($sformatf("rnd%0d", b));
        end

        // Reset in the middle of a character write flushes everything.
        stall = 1'b1;
        applyStimulus(8'h5A);
        waitStarts("mid_head", 1);
        applyStimulus(8'h5B);
        applyStimulus(8'h5C);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        stall = 1'b0;
        clearLogs();
        reset = 1'b0;
        rel   = cyc;
        waitInit();
        checkInitSequence("reinit", rel);
        repeat (30) @(negedge clk);
        checkOutput("flushed_xfers", got_rs.size(), 0);
        checkOutput("flushed_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
